// File: rtl/aes_round_key_gen.sv
// ---------------------------------------------------------------------------
// aes_round_key_gen
//
// Purpose:
//   Expands an AES-128/192/256 cipher key (selected by NK) one 32-bit word
//   per clock into an internal word store, then streams the round keys over
//   a 128-bit valid/ready interface, either in forward order (round 0..NR,
//   for the cipher) or reverse order (round NR..0, for the inverse cipher).
//
// Ports:
//   clk       in   1       rising-edge clock
//   reset     in   1       asynchronous, active-low reset
//   start     in   1       begin a new expansion (only honoured when idle)
//   mode      in   1       stream order, latched with start: 0 fwd, 1 rev
//   key_in    in   32*NK   cipher key, w[0] in the MSBs
//   busy      out  1       expanding or streaming
//   rk_valid  out  1       rk_out / rk_index hold a round key
//   rk_ready  in   1       consumer accepts the current round key
//   rk_out    out  128     {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in MSBs
//   rk_index  out  4       round number r of the key on rk_out
//   done      out  1       one-cycle pulse after the final key transfers
//
// Also contains aes_sbox, the byte substitution used by SubWord.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// aes_sbox
//
// Purpose:
//   Combinational AES S-box: multiplicative inverse in GF(2^8) (computed as
//   x^254, which also maps 0 to 0) followed by the affine transform.
//
// Ports:
//   in_byte   in   8   byte to substitute
//   out_byte  out  8   substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 by square-and-multiply over the exponent bits 1111_1110
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int k = 7; k >= 0; k--) begin
      r = gf_mul(r, r);
      if (e[k]) r = gf_mul(r, x);
    end
    return r;
  endfunction

  logic [7:0] inv_byte;

  always_comb begin
    inv_byte = gf_inv(in_byte);
    out_byte = inv_byte
             ^ {inv_byte[6:0], inv_byte[7]}
             ^ {inv_byte[5:0], inv_byte[7:6]}
             ^ {inv_byte[4:0], inv_byte[7:5]}
             ^ {inv_byte[3:0], inv_byte[7:4]}
             ^ 8'h63;
  end

endmodule

module aes_round_key_gen #(
  parameter  int NK = 8,
  localparam int NR = NK + 6,
  localparam int NW = 4 * (NR + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [32*NK-1:0]  key_in,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [127:0]      rk_out,
  output logic [3:0]        rk_index,
  output logic              done
);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_round_key_gen: NK must be 4, 6 or 8");
  end

  localparam int IW = $clog2(NW);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXPAND,
    S_STREAM
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   w_q [NW];
  logic [31:0]   w_d [NW];
  logic [IW-1:0] i_q, i_d;        // index of the word being generated
  logic [2:0]    j_q, j_d;        // i mod NK, tracked incrementally
  logic [7:0]    rcon_q, rcon_d;  // Rcon for the next i mod NK == 0 word
  logic          mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          rk_valid_q, rk_valid_d;
  logic [127:0]  rk_out_q, rk_out_d;
  logic [3:0]    rk_index_q, rk_index_d;
  logic          done_q, done_d;

  // -------------------------------------------------------------------------
  // Expansion datapath
  // -------------------------------------------------------------------------
  logic [31:0] prev_word;
  logic [31:0] old_word;
  logic [31:0] sub_in;
  logic [31:0] sub_out;
  logic [31:0] temp_word;
  logic [31:0] new_word;

  // i_q stays within NK..NW-1, so both reads are always in range
  assign prev_word = w_q[i_q - IW'(1)];
  assign old_word  = w_q[i_q - IW'(NK)];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*gi +: 8]),
      .out_byte (sub_out[8*gi +: 8])
    );
  end

  always_comb begin
    // RotWord only on the first word of each NK-word group
    sub_in = (j_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;
    if (j_q == 3'd0) begin
      temp_word = sub_out ^ {rcon_q, 24'h000000};
    end else if (NK == 8 && j_q == 3'd4) begin
      temp_word = sub_out;
    end else begin
      temp_word = prev_word;
    end
  end

  assign new_word = old_word ^ temp_word;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic          last_key;
  logic [IW-1:0] base;

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    i_d        = i_q;
    j_d        = j_q;
    rcon_d     = rcon_q;
    mode_d     = mode_q;
    rk_valid_d = rk_valid_q;
    rk_index_d = rk_index_q;
    done_d     = 1'b0;
    last_key   = mode_q ? (rk_index_q == 4'd0) : (rk_index_q == 4'(NR));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int k = 0; k < NK; k++) begin
            w_d[k] = key_in[32*(NK-1-k) +: 32];
          end
          mode_d  = mode;
          i_d     = IW'(NK);
          j_d     = 3'd0;
          rcon_d  = 8'h01;
          state_d = S_EXPAND;
        end
      end

      S_EXPAND: begin
        w_d[i_q] = new_word;
        if (j_q == 3'd0) rcon_d = xtime(rcon_q);
        j_d = (j_q == 3'(NK-1)) ? 3'd0 : j_q + 3'd1;
        if (i_q == IW'(NW-1)) begin
          state_d    = S_STREAM;
          rk_valid_d = 1'b1;
          rk_index_d = mode_q ? 4'(NR) : 4'd0;
        end else begin
          i_d = i_q + IW'(1);
        end
      end

      S_STREAM: begin
        if (rk_ready) begin
          if (last_key) begin
            state_d    = S_IDLE;
            rk_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            rk_index_d = mode_q ? rk_index_q - 4'd1 : rk_index_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    // Read from w_d so the key presented on entry to STREAM can include the
    // word written on that same edge (round NR in reverse mode).
    base     = IW'({rk_index_d, 2'b00});
    rk_out_d = rk_out_q;
    if (rk_valid_d) begin
      rk_out_d = {w_d[base], w_d[base + IW'(1)], w_d[base + IW'(2)], w_d[base + IW'(3)]};
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      w_q        <= '{default: '0};
      i_q        <= IW'(NK);
      j_q        <= 3'd0;
      rcon_q     <= 8'h01;
      mode_q     <= 1'b0;
      busy_q     <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
      rk_index_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      i_q        <= i_d;
      j_q        <= j_d;
      rcon_q     <= rcon_d;
      mode_q     <= mode_d;
      busy_q     <= busy_d;
      rk_valid_q <= rk_valid_d;
      rk_out_q   <= rk_out_d;
      rk_index_q <= rk_index_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign rk_valid = rk_valid_q;
  assign rk_out   = rk_out_q;
  assign rk_index = rk_index_q;
  assign done     = done_q;

endmodule
